// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: synchronizes and filters the device clock, deframes
// 11-bit frames and resolves E0/F0 prefixes into 9-bit make/break key events.
module ps2_scancode_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [8:0] scancode,
  output logic       Pressed,
  output logic       Released,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic                  r_clk_s1, r_clk_s2;
  logic                  r_dat_s1, r_dat_s2;
  logic [FILTER_LEN-1:0] r_filt;
  logic                  r_fclk;
  logic                  r_fall;

  logic [1:0]    r_state;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_sh;
  logic          r_par;
  logic          r_ext, r_brk;
  logic [TW-1:0] r_tmo;

  logic w_frame_ok;
  assign w_frame_ok = r_dat_s2 && ((^r_sh) ^ r_par);

  // Synchronizers and clock filter; the filtered clock only moves when the
  // whole window agrees, so short glitches never produce a fall strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_filt   <= '1;
      r_fclk   <= 1'b1;
      r_fall   <= 1'b0;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
      r_filt   <= {r_filt[FILTER_LEN-2:0], r_clk_s2};
      r_fall   <= 1'b0;
      if (&r_filt) begin
        r_fclk <= 1'b1;
      end else if (~|r_filt) begin
        r_fclk <= 1'b0;
        r_fall <= r_fclk;
      end
    end
  end

  // Frame FSM, byte processing and inter-edge timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_bitcnt  <= '0;
      r_sh      <= '0;
      r_par     <= 1'b0;
      r_ext     <= 1'b0;
      r_brk     <= 1'b0;
      r_tmo     <= '0;
      scancode  <= '0;
      Pressed   <= 1'b0;
      Released  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      Pressed   <= 1'b0;
      Released  <= 1'b0;
      frame_err <= 1'b0;
      if (r_fall) begin
        r_tmo <= '0;
        case (r_state)
          ST_IDLE: begin
            if (!r_dat_s2) begin
              r_state  <= ST_DATA;
              r_bitcnt <= '0;
            end
          end
          ST_DATA: begin
            r_sh     <= {r_dat_s2, r_sh[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) r_state <= ST_PARITY;
          end
          ST_PARITY: begin
            r_par   <= r_dat_s2;
            r_state <= ST_STOP;
          end
          default: begin
            r_state <= ST_IDLE;
            if (!w_frame_ok) begin
              frame_err <= 1'b1;
              r_ext     <= 1'b0;
              r_brk     <= 1'b0;
            end else if (r_sh == 8'hE0) begin
              r_ext <= 1'b1;
            end else if (r_sh == 8'hF0) begin
              r_brk <= 1'b1;
            end else begin
              scancode <= {r_ext, r_sh};
              Released <= r_brk;
              Pressed  <= !r_brk;
              r_ext    <= 1'b0;
              r_brk    <= 1'b0;
            end
          end
        endcase
      end else if (r_state != ST_IDLE) begin
        // A stalled device mid-frame: abort and drop any pending prefix.
        if (r_tmo == TMO_LAST) begin
          r_state   <= ST_IDLE;
          r_tmo     <= '0;
          frame_err <= 1'b1;
          r_ext     <= 1'b0;
          r_brk     <= 1'b0;
        end else begin
          r_tmo <= r_tmo + TW'(1);
        end
      end else begin
        r_tmo <= '0;
      end
    end
  end

endmodule
